// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - LEGv8 opcodes, instruction classes and the ID-stage decoder
package legv8_pkg;

  localparam int DATA_W = 64;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_R     = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_CBZ   = 3'd4,
    CLS_B     = 3'd5
  } instr_class_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_ORR = 2'd3
  } alu_op_t;

  typedef struct packed {
    instr_class_t      cls;
    alu_op_t           alu_op;
    logic [4:0]        src1;
    logic [4:0]        src2;
    logic              use1;
    logic              use2;
    logic [4:0]        dest;
    logic              wen;
    logic [DATA_W-1:0] imm;
  } decode_t;

  // Unused sources keep address 0 and use=0 so they never raise a hazard.
  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t d;
    d = '0;
    case (instr[31:21])
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        d.cls  = CLS_R;
        d.src1 = instr[9:5];
        d.src2 = instr[20:16];
        d.use1 = 1'b1;
        d.use2 = 1'b1;
        d.dest = instr[4:0];
        d.wen  = 1'b1;
        if (instr[31:21] == OP_SUB)      d.alu_op = ALU_SUB;
        else if (instr[31:21] == OP_AND) d.alu_op = ALU_AND;
        else if (instr[31:21] == OP_ORR) d.alu_op = ALU_ORR;
        else                             d.alu_op = ALU_ADD;
      end
      OP_LDUR: begin
        d.cls  = CLS_LOAD;
        d.src1 = instr[9:5];
        d.use1 = 1'b1;
        d.dest = instr[4:0];
        d.wen  = 1'b1;
        d.imm  = {{(DATA_W-9){instr[20]}}, instr[20:12]};
      end
      OP_STUR: begin
        d.cls  = CLS_STORE;
        d.src1 = instr[9:5];
        d.src2 = instr[4:0];
        d.use1 = 1'b1;
        d.use2 = 1'b1;
        d.imm  = {{(DATA_W-9){instr[20]}}, instr[20:12]};
      end
      default: begin
        if (instr[31:24] == OP_CBZ) begin
          d.cls  = CLS_CBZ;
          d.src2 = instr[4:0];
          d.use2 = 1'b1;
          d.imm  = {{(DATA_W-19){instr[23]}}, instr[23:5]};
        end else if (instr[31:26] == OP_B) begin
          d.cls = CLS_B;
          d.imm = {{(DATA_W-26){instr[25]}}, instr[25:0]};
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// rtl/operand_forward_mux.sv - per-source operand resolution and load-use detection
module operand_forward_mux #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] src,
  input  logic              use_src,
  input  logic              exm_wen,
  input  logic [ADDR_W-1:0] exm_dest,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              exm_is_load,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] bank_data,
  output logic [DATA_W-1:0] value,
  output logic              load_hit
);

  logic exm_match;
  assign exm_match = exm_wen && (exm_dest == src);

  // Write-back bypass covers the bank returning the old value on its write cycle.
  always_comb begin
    value = bank_data;
    if (exm_match && !exm_is_load)
      value = exm_data;
    else if (wb_wen && (wb_dest == src))
      value = wb_data;
  end

  assign load_hit = use_src && exm_match && exm_is_load;

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - LEGv8 ID stage: decode, forwarding, load-use stall, ID/EX register
module operand_fetch_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic              exm_wen,
  input  logic [ADDR_W-1:0] exm_dest,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              exm_is_load,
  input  logic              wb_wen,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [2:0]        out_class,
  output logic [1:0]        out_alu_op,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_wen
);
  import legv8_pkg::*;

  decode_t           dec;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              hit1;
  logic              hit2;
  logic              hazard;
  logic              advance;

  assign dec      = decode_instr(in_instr);
  assign rd_addr1 = dec.src1;
  assign rd_addr2 = dec.src2;

  operand_forward_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_a (
    .src        (dec.src1),
    .use_src    (dec.use1),
    .exm_wen    (exm_wen),
    .exm_dest   (exm_dest),
    .exm_data   (exm_data),
    .exm_is_load(exm_is_load),
    .wb_wen     (wb_wen),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .bank_data  (rd_data1),
    .value      (op_a),
    .load_hit   (hit1)
  );

  operand_forward_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_b (
    .src        (dec.src2),
    .use_src    (dec.use2),
    .exm_wen    (exm_wen),
    .exm_dest   (exm_dest),
    .exm_data   (exm_data),
    .exm_is_load(exm_is_load),
    .wb_wen     (wb_wen),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data),
    .bank_data  (rd_data2),
    .value      (op_b),
    .load_hit   (hit2)
  );

  assign hazard   = hit1 || hit2;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !flush;

  // A hazard or flush still advances the register, but with a bubble.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_class  <= CLS_NOP;
      out_alu_op <= '0;
      out_op_a   <= '0;
      out_op_b   <= '0;
      out_imm    <= '0;
      out_dest   <= '0;
      out_wen    <= 1'b0;
    end else if (advance) begin
      out_valid  <= in_valid && in_ready;
      out_class  <= dec.cls;
      out_alu_op <= dec.alu_op;
      out_op_a   <= op_a;
      out_op_b   <= op_b;
      out_imm    <= dec.imm;
      out_dest   <= dec.dest;
      out_wen    <= dec.wen;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
